// File: rtl/oq_dst_full_filter.sv
// Drops each packet on the queues the full evaluator flags and issues one store per accepted queue, lowest index first.
// Optional per-queue saturating drop counters are built when OQ_DROP_CNT_EN is defined.
module oq_dst_full_filter #(
  parameter int NUM_OUTPUT_QUEUES = 8,
  parameter int NUM_OQ_WIDTH      = $clog2(NUM_OUTPUT_QUEUES),
  parameter int DROP_CNT_WIDTH    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         dst_valid,
  input  logic [NUM_OUTPUT_QUEUES-1:0] dst_oq_map,
  output logic                         dst_ready,
  input  logic [NUM_OUTPUT_QUEUES-1:0] full,
  output logic                         store_req,
  output logic [NUM_OQ_WIDTH-1:0]      store_oq,
  input  logic                         store_ack,
  output logic [NUM_OUTPUT_QUEUES-1:0] drop_oq_pulse,
  output logic                         pkt_done,
  output logic                         pkt_dropped,
  input  logic [NUM_OQ_WIDTH-1:0]      rd_oq,
  output logic [DROP_CNT_WIDTH-1:0]    rd_drop_cnt
);

  // state | meaning
  // IDLE  | ready for a new destination map
  // EVAL  | split snapshot map into accepted and dropped queues
  // ISSUE | store_req high for lowest accepted queue, waiting on store_ack
  // GAP   | one idle cycle between consecutive stores
  // DONE  | pkt_done pulse, pkt_dropped valid
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EVAL  = 3'd1,
    S_ISSUE = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                       state_q, state_d;
  logic [NUM_OUTPUT_QUEUES-1:0] map_q, map_d;
  logic [NUM_OUTPUT_QUEUES-1:0] full_q, full_d;
  logic [NUM_OUTPUT_QUEUES-1:0] acc_q, acc_d;
  logic [NUM_OUTPUT_QUEUES-1:0] drop_q, drop_d;
  logic                         dropped_q, dropped_d;
  logic [NUM_OQ_WIDTH-1:0]      low_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      map_q     <= '0;
      full_q    <= '0;
      acc_q     <= '0;
      drop_q    <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      map_q     <= map_d;
      full_q    <= full_d;
      acc_q     <= acc_d;
      drop_q    <= drop_d;
      dropped_q <= dropped_d;
    end
  end

  // Descending scan so the lowest set bit is the last one written.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_OUTPUT_QUEUES - 1; i >= 0; i--) begin
      if (acc_q[i]) low_idx = NUM_OQ_WIDTH'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    map_d     = map_q;
    full_d    = full_q;
    acc_d     = acc_q;
    drop_d    = '0;
    dropped_d = dropped_q;
    case (state_q)
      S_IDLE: begin
        if (dst_valid) begin
          map_d   = dst_oq_map;
          full_d  = full;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        acc_d     = map_q & ~full_q;
        drop_d    = map_q & full_q;
        dropped_d = ((map_q & ~full_q) == '0);
        state_d   = ((map_q & ~full_q) == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        if (store_ack) begin
          acc_d   = acc_q & (acc_q - NUM_OUTPUT_QUEUES'(1));
          state_d = ((acc_q & (acc_q - NUM_OUTPUT_QUEUES'(1))) == '0) ? S_DONE : S_GAP;
        end
      end
      S_GAP:   state_d = S_ISSUE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign dst_ready     = (state_q == S_IDLE);
  assign store_req     = (state_q == S_ISSUE);
  assign store_oq      = (state_q == S_ISSUE) ? low_idx : '0;
  assign drop_oq_pulse = drop_q;
  assign pkt_done      = (state_q == S_DONE);
  assign pkt_dropped   = (state_q == S_DONE) && dropped_q;

`ifdef OQ_DROP_CNT_EN
  logic [DROP_CNT_WIDTH-1:0] cnt_q [NUM_OUTPUT_QUEUES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_OUTPUT_QUEUES; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_OUTPUT_QUEUES; i++) begin
        if (drop_q[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + DROP_CNT_WIDTH'(1);
      end
    end
  end

  assign rd_drop_cnt = cnt_q[rd_oq];
`else
  logic unused_rd_oq;
  assign unused_rd_oq = ^rd_oq;
  assign rd_drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_oq_dst_full_filter.sv
// Directed bench for oq_dst_full_filter; expected values derive from each vector's map and full snapshot.
module tb_oq_dst_full_filter;

  logic       clk = 1'b0;
  logic       reset;
  logic       dst_valid;
  logic [7:0] dst_oq_map;
  logic       dst_ready;
  logic [7:0] full;
  logic       store_req;
  logic [2:0] store_oq;
  logic       store_ack;
  logic [7:0] drop_oq_pulse;
  logic       pkt_done;
  logic       pkt_dropped;
  logic [2:0] rd_oq;
  logic [3:0] rd_drop_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  oq_dst_full_filter #(
    .NUM_OUTPUT_QUEUES(8),
    .NUM_OQ_WIDTH(3),
    .DROP_CNT_WIDTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .dst_valid(dst_valid),
    .dst_oq_map(dst_oq_map),
    .dst_ready(dst_ready),
    .full(full),
    .store_req(store_req),
    .store_oq(store_oq),
    .store_ack(store_ack),
    .drop_oq_pulse(drop_oq_pulse),
    .pkt_done(pkt_done),
    .pkt_dropped(pkt_dropped),
    .rd_oq(rd_oq),
    .rd_drop_cnt(rd_drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Called just after a negedge. Full is inverted after capture so any use of live flags shows up.
  task automatic run_pkt(input string tag, input logic [7:0] map, input logic [7:0] fv, input int ack_wait);
    logic [7:0] acc_exp;
    logic [7:0] drop_seen;
    logic [7:0] stores_seen;
    logic [2:0] held_oq;
    int  nstores, last, waited, cyc, done_cyc, pulse_cyc;
    bit  done, order_ok, stable, rdy_ok, gap_ok, acked_prev;
    logic dropped_obs;
    acc_exp = map & ~fv;
    drop_seen = '0; stores_seen = '0; held_oq = '0;
    nstores = 0; last = -1; waited = 0; cyc = 0; done_cyc = -1; pulse_cyc = 0;
    done = 0; order_ok = 1; stable = 1; rdy_ok = 1; gap_ok = 1; acked_prev = 0;
    dropped_obs = 1'b0;
    dst_valid = 1'b1; dst_oq_map = map; full = fv;
    check({tag, "_rdy_idle"}, 32'(dst_ready), 32'd1);
    @(negedge clk);
    dst_valid = 1'b0; dst_oq_map = '0; full = ~fv;
    cyc = 1;
    while (!done && cyc < 200) begin
      drop_seen |= drop_oq_pulse;
      if (drop_oq_pulse != '0) pulse_cyc++;
      if (dst_ready) rdy_ok = 0;
      if (pkt_done) begin
        done = 1; done_cyc = cyc; dropped_obs = pkt_dropped;
      end
      store_ack = 1'b0;
      if (store_req) begin
        if (acked_prev) gap_ok = 0;
        if (waited == 0) held_oq = store_oq;
        else if (store_oq !== held_oq) stable = 0;
        if (waited >= ack_wait) begin
          store_ack = 1'b1;
          if (int'(store_oq) <= last) order_ok = 0;
          last = int'(store_oq);
          stores_seen[store_oq] = 1'b1;
          nstores++;
          waited = 0;
          acked_prev = 1;
        end else begin
          waited++;
          acked_prev = 0;
        end
      end else begin
        acked_prev = 0;
      end
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    store_ack = 1'b0;
    full = '0;
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_stores"}, 32'(stores_seen), 32'(acc_exp));
    check({tag, "_nstores"}, 32'(nstores), 32'($countones(acc_exp)));
    check({tag, "_order"}, 32'(order_ok), 32'd1);
    check({tag, "_drops"}, 32'(drop_seen), 32'(map & fv));
    check({tag, "_pulse_len"}, 32'(pulse_cyc), ((map & fv) != '0) ? 32'd1 : 32'd0);
    check({tag, "_dropped"}, 32'(dropped_obs), (acc_exp == '0) ? 32'd1 : 32'd0);
    check({tag, "_stable"}, 32'(stable), 32'd1);
    check({tag, "_gap"}, 32'(gap_ok), 32'd1);
    check({tag, "_rdy_busy"}, 32'(rdy_ok), 32'd1);
    if (acc_exp == '0) check({tag, "_latency"}, 32'(done_cyc), 32'd2);
    @(negedge clk);
    check({tag, "_rdy_after"}, 32'(dst_ready), 32'd1);
    check({tag, "_done_clr"}, 32'(pkt_done), 32'd0);
  endtask

  initial begin
    bit seen_done;
    int guard;
    reset = 1'b1; dst_valid = 1'b0; dst_oq_map = '0; full = '0; store_ack = 1'b0; rd_oq = '0;
    @(negedge clk);
    check("rst_rdy", 32'(dst_ready), 32'd1);
    check("rst_req", 32'(store_req), 32'd0);
    check("rst_oq", 32'(store_oq), 32'd0);
    check("rst_drop", 32'(drop_oq_pulse), 32'd0);
    check("rst_done", 32'(pkt_done), 32'd0);
    check("rst_dropped", 32'(pkt_dropped), 32'd0);
    check("rst_cnt", 32'(rd_drop_cnt), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_pkt("t1", 8'b0000_0101, 8'h00, 0);
    run_pkt("t2", 8'b0000_0101, 8'b0000_0100, 0);
    run_pkt("t3", 8'h81, 8'hFF, 0);
    run_pkt("t4", 8'h12, 8'h00, 5);
    run_pkt("zero", 8'h00, 8'h00, 0);
    run_pkt("mix", 8'hFF, 8'h5A, 1);
    run_pkt("top", 8'h80, 8'h00, 2);

    // Reset mid-ISSUE: store_req must drop without waiting for a clock edge.
    dst_valid = 1'b1; dst_oq_map = 8'h0F; full = 8'h00;
    @(negedge clk);
    dst_valid = 1'b0;
    guard = 0;
    while (!store_req && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("t5_req_before", 32'(store_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t5_req_async", 32'(store_req), 32'd0);
    check("t5_rdy_async", 32'(dst_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (pkt_done || store_req) seen_done = 1;
    end
    check("t5_no_done", 32'(seen_done), 32'd0);
    check("t5_rdy_after", 32'(dst_ready), 32'd1);

    do_reset();
`ifdef OQ_DROP_CNT_EN
    for (int k = 0; k < 20; k++) begin
      run_pkt("t6", 8'h08, 8'hFF, 0);
      rd_oq = 3'd3;
      #1;
      check("t6_cnt_run", 32'(rd_drop_cnt), (k + 1 < 15) ? 32'(k + 1) : 32'd15);
    end
    rd_oq = 3'd3;
    #1;
    check("t6_cnt_sat", 32'(rd_drop_cnt), 32'hF);
    for (int q = 0; q < 8; q++) begin
      if (q != 3) begin
        rd_oq = 3'(q);
        #1;
        check("t6_cnt_other", 32'(rd_drop_cnt), 32'd0);
      end
    end
`else
    for (int k = 0; k < 3; k++) run_pkt("t6", 8'h08, 8'hFF, 0);
    rd_oq = 3'd3;
    #1;
    check("t6_cnt_tied", 32'(rd_drop_cnt), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
